// File: rtl/mem_stage_ctrl_if.sv
// Handshake and data bundle between EX/MEM, the MEM stage and MEM/WB.
interface mem_stage_ctrl_if #(
  parameter int unsigned W    = 16,
  parameter int unsigned AW   = 11,
  parameter int unsigned WB_W = 3
);
  logic            in_valid;
  logic            in_ready;
  logic            mem_read;
  logic            mem_write;
  logic [1:0]      addr_sel;
  logic            wd_sel;
  logic [1:0]      sp_op;
  logic [WB_W-1:0] wb_in;
  logic [W-1:0]    rsrc;
  logic [W-1:0]    rdst;
  logic [W-1:0]    alu;
  logic [W-1:0]    imm;
  logic            out_valid;
  logic [WB_W-1:0] wb_out;
  logic [W-1:0]    imm_out;
  logic [W-1:0]    alu_out;
  logic [W-1:0]    mem_out;
  logic [AW-1:0]   sp_out;

  modport master (
    output in_valid, mem_read, mem_write, addr_sel, wd_sel, sp_op,
           wb_in, rsrc, rdst, alu, imm,
    input  in_ready, out_valid, wb_out, imm_out, alu_out, mem_out, sp_out
  );

  modport slave (
    input  in_valid, mem_read, mem_write, addr_sel, wd_sel, sp_op,
           wb_in, rsrc, rdst, alu, imm,
    output in_ready, out_valid, wb_out, imm_out, alu_out, mem_out, sp_out
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: data memory, stack pointer, multi-cycle access FSM
// and registered MEM/WB output bundle.
module mem_stage_ctrl #(
  parameter int unsigned   W       = 16,
  parameter int unsigned   AW      = 11,
  parameter int unsigned   LAT     = 1,
  parameter int unsigned   WB_W    = 3,
  parameter logic [AW-1:0] SP_INIT = AW'((2 ** AW) - 1)
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  logic [1:0]      cnt;
  logic            ready;
  logic [AW-1:0]   sp;
  logic [W-1:0]    mem [0:(2**AW)-1];

  // transaction captured at accept, used while BUSY
  logic [AW-1:0]   addr_q;
  logic [W-1:0]    wd_q;
  logic            rd_q, wr_q;
  logic [1:0]      spop_q;
  logic [WB_W-1:0] wb_q;
  logic [W-1:0]    imm_q, alu_q;

  logic            accept, access_d, busy_done, finish, commit;
  logic [AW-1:0]   addr_d, c_addr;
  logic [W-1:0]    wd_d, c_wd, c_imm, c_alu;
  logic [WB_W-1:0] c_wb;
  logic            c_rd, c_wr, c_acc;
  logic [1:0]      c_spop;

  // upper operand bits never address the array
  logic unused_hi;
  assign unused_hi = &{1'b0, bus.rsrc[W-1:AW], bus.rdst[W-1:AW], bus.alu[W-1:AW]};

  // Resolve address/data and pick the transaction that completes this edge:
  // the live inputs on a direct accept, the captured copy when leaving BUSY.
  always_comb begin
    accept   = bus.in_valid && ready;
    access_d = bus.mem_read || bus.mem_write;
    addr_d   = '0;
    unique case (bus.addr_sel)
      2'd0:    addr_d = bus.rsrc[AW-1:0];
      2'd1:    addr_d = bus.rdst[AW-1:0];
      2'd2:    addr_d = (bus.sp_op == 2'b10) ? sp + AW'(1) : sp;
      default: addr_d = bus.alu[AW-1:0];
    endcase
    wd_d      = bus.wd_sel ? bus.rdst : bus.rsrc;
    busy_done = (state == BUSY) && (cnt == 2'd1);
    finish    = busy_done || (accept && (!access_d || (LAT == 1)));
    if (state == BUSY) begin
      c_addr = addr_q;  c_wd  = wd_q;   c_rd  = rd_q && !wr_q; c_wr = wr_q;
      c_acc  = rd_q || wr_q; c_spop = spop_q;
      c_wb   = wb_q;    c_imm = imm_q;  c_alu = alu_q;
    end else begin
      c_addr = addr_d;  c_wd  = wd_d;   c_rd  = bus.mem_read && !bus.mem_write;
      c_wr   = bus.mem_write; c_acc = access_d; c_spop = bus.sp_op;
      c_wb   = bus.wb_in; c_imm = bus.imm; c_alu = bus.alu;
    end
    commit = finish && c_acc;
  end

  // Array write on the edge that enters RESP; suppressed while in reset
  always_ff @(posedge clk) begin
    if (rst && commit && c_wr) mem[c_addr] <= c_wd;
  end

  // Control FSM, SP and registered MEM/WB outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b1;
      sp        <= SP_INIT;
      addr_q    <= '0;
      wd_q      <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      spop_q    <= '0;
      wb_q      <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      bus.out_valid <= 1'b0;
      bus.wb_out    <= '0;
      bus.imm_out   <= '0;
      bus.alu_out   <= '0;
      bus.mem_out   <= '0;
    end else begin
      bus.out_valid <= finish;
      if (finish) begin
        bus.wb_out  <= c_wb;
        bus.imm_out <= c_imm;
        bus.alu_out <= c_alu;
        bus.mem_out <= c_rd ? mem[c_addr] : '0;
      end
      if (commit) begin
        case (c_spop)
          2'b01:   sp <= sp - AW'(1);
          2'b10:   sp <= sp + AW'(1);
          default: sp <= sp;
        endcase
      end
      case (state)
        BUSY: begin
          if (busy_done) begin
            state <= RESP;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          if (accept) begin
            addr_q <= addr_d;
            wd_q   <= wd_d;
            rd_q   <= bus.mem_read;
            wr_q   <= bus.mem_write;
            spop_q <= bus.sp_op;
            wb_q   <= bus.wb_in;
            imm_q  <= bus.imm;
            alu_q  <= bus.alu;
            if (finish) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= 2'(LAT - 1);
              ready <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready = ready;
  assign bus.sp_out   = sp;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: one LAT=1 and one LAT=3 instance,
// expected bundles queued at issue and checked when out_valid appears.
module tb_mem_stage_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3, v1, v3;
  logic        mr, mw, wds;
  logic [1:0]  as, spo;
  logic [2:0]  wb;
  logic [15:0] rs, rdv, al, im;

  mem_stage_ctrl_if #(.W(16), .AW(11), .WB_W(3)) b1 ();
  mem_stage_ctrl_if #(.W(16), .AW(11), .WB_W(3)) b3 ();

  assign b1.in_valid = v1;  assign b3.in_valid = v3;
  assign b1.mem_read = mr;  assign b3.mem_read = mr;
  assign b1.mem_write = mw; assign b3.mem_write = mw;
  assign b1.addr_sel = as;  assign b3.addr_sel = as;
  assign b1.wd_sel = wds;   assign b3.wd_sel = wds;
  assign b1.sp_op = spo;    assign b3.sp_op = spo;
  assign b1.wb_in = wb;     assign b3.wb_in = wb;
  assign b1.rsrc = rs;      assign b3.rsrc = rs;
  assign b1.rdst = rdv;     assign b3.rdst = rdv;
  assign b1.alu = al;       assign b3.alu = al;
  assign b1.imm = im;       assign b3.imm = im;

  mem_stage_ctrl #(.W(16), .AW(11), .LAT(1), .WB_W(3)) u1 (.clk(clk), .rst(rst1), .bus(b1));
  mem_stage_ctrl #(.W(16), .AW(11), .LAT(3), .WB_W(3)) u3 (.clk(clk), .rst(rst3), .bus(b3));

  typedef struct {
    string       tag;
    logic [15:0] mem, alu, imm;
    logic [2:0]  wb;
    logic [10:0] sp;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ov(input int w);
    return (w == 0) ? b1.out_valid : b3.out_valid;
  endfunction
  function automatic logic rdy(input int w);
    return (w == 0) ? b1.in_ready : b3.in_ready;
  endfunction

  // Issue one transaction with the current drive values and check its response.
  task automatic go(input int w, input string tag, input logic [15:0] emem,
                    input logic [10:0] esp, input int elat, input bit hold);
    exp_t e;
    int n, busy;
    e.tag = tag; e.mem = emem; e.alu = al; e.imm = im; e.wb = wb; e.sp = esp;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, "_rdy"}, rdy(w), 1);
    if (w == 0) v1 = 1'b1; else v3 = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin v1 = 1'b0; v3 = 1'b0; end
    n = 0; busy = 0;
    while (n < 10) begin
      @(negedge clk); n++;
      if (ov(w)) break;
      if (!rdy(w)) busy++;
    end
    v1 = 1'b0; v3 = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_lat"}, n, elat);
    chk({e.tag, "_busy"}, busy, elat - 1);
    chk({e.tag, "_mem"}, (w == 0) ? b1.mem_out : b3.mem_out, e.mem);
    chk({e.tag, "_alu"}, (w == 0) ? b1.alu_out : b3.alu_out, e.alu);
    chk({e.tag, "_imm"}, (w == 0) ? b1.imm_out : b3.imm_out, e.imm);
    chk({e.tag, "_wb"},  (w == 0) ? b1.wb_out  : b3.wb_out,  e.wb);
    chk({e.tag, "_sp"},  (w == 0) ? b1.sp_out  : b3.sp_out,  e.sp);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int w);
    @(posedge clk); #1;
    if (w == 0) rst1 = 1'b0; else rst3 = 1'b0;
    #2;
    chk("rst_valid", ov(w), 0);
    chk("rst_ready", rdy(w), 1);
    chk("rst_mem", (w == 0) ? b1.mem_out : b3.mem_out, 0);
    chk("rst_alu", (w == 0) ? b1.alu_out : b3.alu_out, 0);
    chk("rst_wb",  (w == 0) ? b1.wb_out  : b3.wb_out,  0);
    chk("rst_sp",  (w == 0) ? b1.sp_out  : b3.sp_out,  11'h7FF);
    @(posedge clk); #1;
    rst1 = 1'b1; rst3 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst1 = 1'b1; rst3 = 1'b1; v1 = 1'b0; v3 = 1'b0;
    mr = 1'b0; mw = 1'b0; wds = 1'b0; as = 2'd0; spo = 2'd0;
    wb = 3'd0; rs = '0; rdv = '0; al = '0; im = '0;
    do_reset(0);
    do_reset(1);

    // store BEEF at rdst=5, load it back
    mw = 1; mr = 0; as = 2'd1; rdv = 16'd5; rs = 16'hBEEF; al = 16'h0001; im = 16'h0002; wb = 3'b001;
    go(0, "t1_st", 16'h0000, 11'h7FF, 1, 0);
    mw = 0; mr = 1;
    go(0, "t1_ld", 16'hBEEF, 11'h7FF, 1, 0);

    // push/push/pop/pop
    as = 2'd2; mr = 0; mw = 1; spo = 2'b01; rs = 16'h1111;
    go(0, "t3_push1", 16'h0000, 11'h7FE, 1, 0);
    rs = 16'h2222;
    go(0, "t3_push2", 16'h0000, 11'h7FD, 1, 0);
    mw = 0; mr = 1; spo = 2'b10;
    go(0, "t3_pop1", 16'h2222, 11'h7FE, 1, 0);
    go(0, "t3_pop2", 16'h1111, 11'h7FF, 1, 0);

    // write data taken from rdst, address from rsrc
    mr = 0; mw = 1; spo = 2'b00; as = 2'd0; rs = 16'h0012; wds = 1; rdv = 16'h5A5A;
    go(0, "wd_st", 16'h0000, 11'h7FF, 1, 0);
    mw = 0; mr = 1; wds = 0;
    go(0, "wd_ld", 16'h5A5A, 11'h7FF, 1, 0);

    // wrap: seed addr 0, reset, pop from top wraps to 0, push at 0 wraps SP
    mr = 0; mw = 1; as = 2'd1; rdv = 16'h0000; rs = 16'hC0DE;
    go(0, "t4_seed", 16'h0000, 11'h7FF, 1, 0);
    do_reset(0);
    mw = 0; mr = 1; as = 2'd2; spo = 2'b10;
    go(0, "t4_pop", 16'hC0DE, 11'h000, 1, 0);
    mr = 0; mw = 1; spo = 2'b01; rs = 16'h3333;
    go(0, "t4_push", 16'h0000, 11'h7FF, 1, 0);
    mw = 0; mr = 1; spo = 2'b00; as = 2'd0; rs = 16'h0000;
    go(0, "t4_ld0", 16'h3333, 11'h7FF, 1, 0);

    // read+write together behaves as a write
    mr = 1; mw = 1; as = 2'd1; rdv = 16'd9; rs = 16'h00A5; al = 16'h1234; im = 16'h0042; wb = 3'b101;
    go(0, "t5_rw", 16'h0000, 11'h7FF, 1, 0);
    mw = 0; as = 2'd3; al = 16'h0009;
    go(0, "t5_ld", 16'h00A5, 11'h7FF, 1, 0);

    // LAT=3: seed addr 7, load with in_valid held through BUSY
    mr = 0; mw = 1; as = 2'd1; rdv = 16'd7; rs = 16'h0000;
    go(1, "t2_seed", 16'h0000, 11'h7FF, 3, 0);
    mw = 0; mr = 1;
    go(1, "t2_ld", 16'h0000, 11'h7FF, 3, 1);
    n = 0;
    repeat (5) begin @(negedge clk); if (b3.out_valid) n++; end
    chk("t2_once", n, 0);
    @(posedge clk); #1;

    // LAT=3 no-access completes in one cycle
    mr = 0; mw = 0; al = 16'hABCD;
    go(1, "t2_none", 16'h0000, 11'h7FF, 1, 0);

    // LAT=3 push, then store aborted by reset in BUSY
    mw = 1; as = 2'd2; spo = 2'b01; rs = 16'h7777;
    go(1, "t6_push", 16'h0000, 11'h7FE, 3, 0);
    as = 2'd1; spo = 2'b00; rdv = 16'd7; rs = 16'hDEAD;
    @(negedge clk); v3 = 1'b1;
    @(posedge clk); #1; v3 = 1'b0;
    @(negedge clk);
    chk("t6_busy", b3.in_ready, 0);
    rst3 = 1'b0; #1;
    chk("t6_valid", b3.out_valid, 0);
    chk("t6_sp", b3.sp_out, 11'h7FF);
    @(posedge clk); #1; rst3 = 1'b1;
    n = 0;
    repeat (4) begin @(negedge clk); if (b3.out_valid) n++; end
    chk("t6_nopulse", n, 0);
    mw = 0; mr = 1;
    go(1, "t6_ld7", 16'h0000, 11'h7FF, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
